// File: rtl/led_sequencer.sv
// LED pattern sequencer: off/blink/chase/bounce advanced by divider ticks,
// with PWM brightness gating on the registered LED drive.
module led_sequencer #(
  parameter int NUM_LEDS = 4,
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic [7:0]          period,
  input  logic [PWM_BITS-1:0] duty,
  output logic [NUM_LEDS-1:0] leds,
  output logic                step
);

  localparam int PW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [PW-1:0] LAST = PW'(NUM_LEDS - 1);

  typedef enum logic [1:0] {
    M_OFF    = 2'b00,
    M_BLINK  = 2'b01,
    M_CHASE  = 2'b10,
    M_BOUNCE = 2'b11
  } mode_e;

  mode_e               mode_q, mode_d;
  logic [7:0]          tick_cnt, cnt_d;
  logic [PW-1:0]       pos, pos_d;
  logic                dir, dir_d;
  logic                phase, phase_d;
  logic                step_d;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [NUM_LEDS-1:0] pattern;
  logic                gate;

  always_comb begin
    mode_d  = mode_e'(mode);
    cnt_d   = tick_cnt;
    pos_d   = pos;
    dir_d   = dir;
    phase_d = phase;
    step_d  = 1'b0;
    if (mode_d != mode_q) begin
      cnt_d   = '0;
      pos_d   = '0;
      dir_d   = 1'b0;
      phase_d = 1'b0;
    end else if (tick && en && mode_q != M_OFF) begin
      // >= keeps a lowered period from wrapping the count
      if (tick_cnt >= period) begin
        cnt_d  = '0;
        step_d = 1'b1;
        unique case (mode_q)
          M_BLINK: phase_d = ~phase;
          M_CHASE: pos_d = (pos == LAST) ? '0 : pos + PW'(1);
          M_BOUNCE: begin
            if (!dir) begin
              pos_d = pos + PW'(1);
              if (pos_d == LAST) dir_d = 1'b1;
            end else begin
              pos_d = pos - PW'(1);
              if (pos_d == '0) dir_d = 1'b0;
            end
          end
          default: ;
        endcase
      end else begin
        cnt_d = tick_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    pattern = '0;
    unique case (1'b1)
      (mode_q == M_BLINK): pattern = {NUM_LEDS{phase}};
      (mode_q == M_CHASE),
      (mode_q == M_BOUNCE): pattern = NUM_LEDS'(1) << pos;
      default: ;
    endcase
  end

  assign gate = (pwm_cnt < duty) || (&duty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= M_OFF;
      tick_cnt <= '0;
      pos      <= '0;
      dir      <= 1'b0;
      phase    <= 1'b0;
      pwm_cnt  <= '0;
      leds     <= '0;
      step     <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      tick_cnt <= cnt_d;
      pos      <= pos_d;
      dir      <= dir_d;
      phase    <= phase_d;
      pwm_cnt  <= pwm_cnt + PWM_BITS'(1);
      leds     <= pattern & {NUM_LEDS{gate}};
      step     <= step_d;
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Testbench for led_sequencer: scenario tasks plus randomized traffic,
// checked cycle by cycle against an advance-count reference model.
module tb_led_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       en = 1'b1;
  logic [1:0] mode = 2'b00;
  logic [7:0] period = 8'd0;
  logic [3:0] duty = 4'hF;
  logic [3:0] leds;
  logic       step;

  int nvec = 0;
  int nfail = 0;

  // model: pattern derived from number of advances since mode entry
  int         m_mode_q, m_cnt, m_n, m_pwm;
  logic [3:0] m_leds;
  logic       m_step;

  led_sequencer #(.NUM_LEDS(4), .PWM_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .en(en), .mode(mode),
    .period(period), .duty(duty), .leds(leds), .step(step)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] pat(int md, int n);
    int r, p;
    case (md)
      1: return (n % 2 == 1) ? 4'hF : 4'h0;
      2: return 4'(1 << (n % 4));
      3: begin
        r = n % 6;
        p = (r < 4) ? r : 6 - r;
        return 4'(1 << p);
      end
      default: return 4'h0;
    endcase
  endfunction

  task automatic mreset();
    m_mode_q = 0; m_cnt = 0; m_n = 0; m_pwm = 0;
    m_leds = 4'h0; m_step = 1'b0;
  endtask

  task automatic medge();
    logic [3:0] nl;
    logic g;
    g = ((m_pwm % 16) < int'(duty)) || (duty == 4'hF);
    nl = g ? pat(m_mode_q, m_n) : 4'h0;
    m_step = 1'b0;
    if (int'(mode) != m_mode_q) begin
      m_cnt = 0; m_n = 0;
    end else if (tick && en && m_mode_q != 0) begin
      if (m_cnt >= int'(period)) begin
        m_cnt = 0; m_n++; m_step = 1'b1;
      end else begin
        m_cnt++;
      end
    end
    m_mode_q = int'(mode);
    m_pwm++;
    m_leds = nl;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst_n) mreset();
    else medge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cyc();
    nvec++;
    if (leds !== 4'h0 || step !== 1'b0) begin
      nfail++;
      $display("FAIL reset: leds=%b step=%b, expected 0000 0", leds, step);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_chase();
    int steps = 0;
    mode = 2'b10; period = 8'd0; duty = 4'hF; en = 1'b1;
    for (int c = 0; c < 48; c++) begin
      tick = (c % 8 == 4);
      cyc();
      if (step) steps++;
      nvec++;
      if (leds !== m_leds || step !== m_step) begin
        nfail++;
        $display("FAIL chase c=%0d: leds=%b step=%b, expected %b %b",
                 c, leds, step, m_leds, m_step);
      end
    end
    tick = 1'b0;
    nvec++;
    if (steps != 6) begin
      nfail++;
      $display("FAIL chase_steps: got %0d, expected 6", steps);
    end
  endtask

  task automatic test_bounce();
    int steps = 0;
    mode = 2'b11; period = 8'd2; duty = 4'hF;
    for (int t = 0; t < 20; t++) begin
      tick = 1'b0;
      repeat ($urandom_range(1, 5)) begin
        cyc();
        nvec++;
        if (leds !== m_leds || step !== m_step) begin
          nfail++;
          $display("FAIL bounce gap: leds=%b step=%b, expected %b %b",
                   leds, step, m_leds, m_step);
        end
      end
      tick = 1'b1;
      cyc();
      if (step) steps++;
      nvec++;
      if (leds !== m_leds || step !== m_step) begin
        nfail++;
        $display("FAIL bounce t=%0d: leds=%b step=%b, expected %b %b",
                 t, leds, step, m_leds, m_step);
      end
    end
    tick = 1'b0;
    nvec++;
    if (steps != 6) begin
      nfail++;
      $display("FAIL bounce_steps: got %0d, expected 6", steps);
    end
  endtask

  task automatic test_blink_pwm();
    mode = 2'b01; period = 8'd0; duty = 4'd4;
    for (int c = 0; c < 200; c++) begin
      tick = (c % 37 == 5);
      cyc();
      nvec++;
      if (leds !== m_leds || step !== m_step) begin
        nfail++;
        $display("FAIL blink c=%0d: leds=%b step=%b, expected %b %b",
                 c, leds, step, m_leds, m_step);
      end
    end
    duty = 4'd0;
    for (int c = 0; c < 100; c++) begin
      tick = (c % 21 == 3);
      cyc();
      nvec++;
      if (leds !== 4'h0 || step !== m_step) begin
        nfail++;
        $display("FAIL blink_dark c=%0d: leds=%b step=%b, expected 0000 %b",
                 c, leds, step, m_step);
      end
    end
    tick = 1'b0;
  endtask

  task automatic test_period_change();
    int steps = 0;
    mode = 2'b10; period = 8'd200; duty = 4'hF; tick = 1'b0;
    cyc();
    for (int t = 0; t < 50; t++) begin
      tick = 1'b1; cyc(); tick = 1'b0; cyc();
      nvec++;
      if (leds !== m_leds || step !== m_step) begin
        nfail++;
        $display("FAIL p200 t=%0d: leds=%b step=%b, expected %b %b",
                 t, leds, step, m_leds, m_step);
      end
    end
    period = 8'd3;
    tick = 1'b1;
    cyc();
    nvec++;
    if (step !== 1'b1) begin
      nfail++;
      $display("FAIL period_drop: step=%b, expected 1", step);
    end
    tick = 1'b0;
    cyc();
    for (int t = 0; t < 12; t++) begin
      tick = 1'b1; cyc();
      if (step) steps++;
      nvec++;
      if (leds !== m_leds || step !== m_step) begin
        nfail++;
        $display("FAIL p3 t=%0d: leds=%b step=%b, expected %b %b",
                 t, leds, step, m_leds, m_step);
      end
      tick = 1'b0; cyc();
    end
    nvec++;
    if (steps != 3) begin
      nfail++;
      $display("FAIL p3_steps: got %0d, expected 3", steps);
    end
  endtask

  task automatic test_mode_tick();
    logic [3:0] held;
    mode = 2'b01; tick = 1'b1;
    cyc();
    tick = 1'b0;
    nvec++;
    if (step !== 1'b0) begin
      nfail++;
      $display("FAIL mode_tick_step: step=%b, expected 0", step);
    end
    cyc();
    nvec++;
    if (leds !== 4'h0) begin
      nfail++;
      $display("FAIL mode_tick_leds: leds=%b, expected 0000", leds);
    end
    mode = 2'b10; period = 8'd0;
    cyc();
    repeat (2) begin tick = 1'b1; cyc(); tick = 1'b0; cyc(); end
    en = 1'b0;
    held = m_leds;
    for (int t = 0; t < 10; t++) begin
      tick = 1'b1; cyc(); tick = 1'b0;
      repeat (2) begin
        nvec++;
        if (leds !== held || step !== 1'b0) begin
          nfail++;
          $display("FAIL en_hold t=%0d: leds=%b step=%b, expected %b 0",
                   t, leds, step, held);
        end
        cyc();
      end
    end
    en = 1'b1;
  endtask

  task automatic test_async_reset();
    int guard = 0;
    mode = 2'b10; period = 8'd0; duty = 4'hF;
    while (m_leds != 4'b0100 && guard < 50) begin
      tick = 1'b1; cyc(); tick = 1'b0; cyc(); cyc();
      guard++;
    end
    nvec++;
    if (leds !== 4'b0100) begin
      nfail++;
      $display("FAIL pre_reset: leds=%b, expected 0100", leds);
    end
    #2 rst_n = 1'b0;
    #1;
    nvec++;
    if (leds !== 4'h0 || step !== 1'b0) begin
      nfail++;
      $display("FAIL async_reset: leds=%b step=%b, expected 0000 0",
               leds, step);
    end
    mreset();
    #1 rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick = (c % 5 == 3);
      cyc();
      nvec++;
      if (leds !== m_leds || step !== m_step) begin
        nfail++;
        $display("FAIL post_reset c=%0d: leds=%b step=%b, expected %b %b",
                 c, leds, step, m_leds, m_step);
      end
    end
    tick = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 3) mode = 2'($urandom);
      if ($urandom_range(0, 99) < 5) duty = 4'($urandom);
      if ($urandom_range(0, 99) < 4) period = 8'($urandom_range(0, 3));
      en = ($urandom_range(0, 9) != 0);
      tick = !tick && ($urandom_range(0, 2) == 0);
      cyc();
      nvec++;
      if (leds !== m_leds || step !== m_step) begin
        nfail++;
        $display("FAIL random c=%0d: leds=%b step=%b, expected %b %b",
                 c, leds, step, m_leds, m_step);
      end
    end
    tick = 1'b0;
  endtask

  initial begin
    mreset();
    test_reset();
    test_chase();
    test_bounce();
    test_blink_pwm();
    test_period_change();
    test_mode_tick();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
